// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder for the MEM stage. It serves one read
//                or write request at a time with a fixed latency and raises
//                STALL while the access is outstanding. Word-addressed,
//                big-endian byte lanes, byte-lane masked writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write,
    input  logic [1:0]  write_size,
    output logic [31:0] data_read,
    output logic        STALL,
    output logic        ACK,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);
    localparam int         c_words    = 1 << ADDR_WIDTH;

    // Storage; deliberately not reset
    logic [31:0] mem [0:c_words-1];

    // Registered state and latched request
    state_t                state_q,     state_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q,       idx_d;
    logic [31:0]           wdata_q,     wdata_d;
    logic [3:0]            mask_q,      mask_d;
    logic                  is_read_q,   is_read_d;
    logic                  is_write_q,  is_write_d;
    logic                  req_err_q,   req_err_d;
    logic [31:0]           data_read_q, data_read_d;
    logic                  ack_q,       ack_d;
    logic                  err_q,       err_d;

    // Decoded incoming request
    logic                  w_req;
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_addr_err;
    logic                  w_write_err;
    logic                  w_req_err;
    logic [3:0]            w_mask;
    logic [31:0]           w_wdata;

    // Access actually performed this cycle (live inputs on the direct IDLE->DONE path)
    logic                  w_acc_sel_live;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic [3:0]            w_acc_mask;
    logic [31:0]           w_acc_wdata;
    logic                  w_acc_read;
    logic                  w_acc_write;
    logic                  w_acc_err;
    logic                  w_enter_done;
    logic                  w_mem_we;

    assign w_req       = MemRead | MemWrite;
    assign w_off       = data_address[1:0];
    assign w_idx       = data_address[ADDR_WIDTH+1:2];
    assign w_addr_err  = (data_address >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_write_err = MemWrite & ((write_size == 2'd3) |
                                     ((write_size == 2'd1) & w_off[0]) |
                                     ((write_size == 2'd2) & (w_off != 2'd0)));
    assign w_req_err   = (MemRead & MemWrite) | w_addr_err | w_write_err;

    // Byte-lane mask (bit 3 = bits [31:24] = offset 0) and lane-replicated write data
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = data_write;
        case (write_size)
            2'd0: begin
                w_mask  = 4'b0001 << (2'd3 - w_off);
                w_wdata = {4{data_write[7:0]}};
            end
            2'd1: begin
                w_mask  = w_off[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{data_write[15:0]}};
            end
            2'd2: begin
                w_mask  = 4'b1111;
                w_wdata = data_write;
            end
            default: begin
                w_mask  = 4'b0000;
                w_wdata = data_write;
            end
        endcase
    end

    assign w_acc_sel_live = (state_q == S_IDLE);
    assign w_acc_idx      = w_acc_sel_live ? w_idx     : idx_q;
    assign w_acc_mask     = w_acc_sel_live ? w_mask    : mask_q;
    assign w_acc_wdata    = w_acc_sel_live ? w_wdata   : wdata_q;
    assign w_acc_read     = w_acc_sel_live ? MemRead   : is_read_q;
    assign w_acc_write    = w_acc_sel_live ? MemWrite  : is_write_q;
    assign w_acc_err      = w_acc_sel_live ? w_req_err : req_err_q;

    assign w_enter_done = ((state_q == S_IDLE) & w_req & (LATENCY == 1)) |
                          ((state_q == S_BUSY) & (cnt_q == 4'd1));

    // A reset arriving on the completing edge must not commit the write
    assign w_mem_we = w_enter_done & w_acc_write & ~w_acc_err & ~RESET;

    assign STALL     = ~RESET & ((state_q == S_BUSY) | ((state_q == S_IDLE) & w_req));
    assign data_read = data_read_q;
    assign ACK       = ack_q;
    assign ERR       = err_q;

    // Next-state, request latching and completion outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        is_read_d   = is_read_q;
        is_write_d  = is_write_q;
        req_err_d   = req_err_q;
        data_read_d = data_read_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    idx_d      = w_idx;
                    wdata_d    = w_wdata;
                    mask_d     = w_mask;
                    is_read_d  = MemRead;
                    is_write_d = MemWrite;
                    req_err_d  = w_req_err;
                    cnt_d      = c_cnt_init;
                    state_d    = (LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_enter_done) begin
            ack_d = 1'b1;
            err_d = w_acc_err;
            if (w_acc_read) begin
                data_read_d = w_acc_err ? 32'd0 : mem[w_acc_idx];
            end
        end
    end

    // Control and output registers, asynchronously cleared
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            mask_q      <= 4'd0;
            is_read_q   <= 1'b0;
            is_write_q  <= 1'b0;
            req_err_q   <= 1'b0;
            data_read_q <= 32'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            is_read_q   <= is_read_d;
            is_write_q  <= is_write_d;
            req_err_q   <= req_err_d;
            data_read_q <= data_read_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    // Byte-lane masked write on the edge that enters DONE
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_mask[b]) begin
                    mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MEM stage's data-memory request port. It accepts one read or write request at a time and returns the addressed big-endian word after a fixed, parameterised latency. It drives a STALL line that the pipeline control uses as a FREEZE source while an access is outstanding. Reads always return the full aligned word; byte and halfword extraction stays in the MEM stage. Writes are byte-lane masked here.

## Interface
- ADDR_WIDTH, 10: word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: stall cycles per access, legal range 1..15.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MemRead  in  1  read request, level, held by requester until STALL low.
- MemWrite  in  1  write request, level, held until STALL low.
- data_address  in  32  byte address.
- data_write  in  32  write data, right-justified for byte/half (byte in [7:0], half in [15:0]).
- write_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as error).
- data_read  out  32  aligned word read; valid in DONE; holds otherwise.
- STALL  out  1  combinational; high while a request is not yet completed.
- ACK  out  1  one-cycle pulse in DONE.
- ERR  out  1  one-cycle pulse in DONE for an illegal request.

## Operation
- States: IDLE, BUSY, DONE; 4-bit down-counter cnt.
- IDLE: req = MemRead | MemWrite. STALL = req. At the edge with req, latch address, data, size and op.
  - Set cnt = LATENCY-1.
  - Go to DONE if LATENCY == 1, else to BUSY.
- BUSY: STALL = 1; cnt decrements each edge; when cnt == 1, go to DONE at that edge.
- Access is performed on the edge entering DONE:
  - Read: data_read <= mem[addr[ADDR_WIDTH+1:2]], low two address bits ignored.
  - Write: merge under byte-lane mask.
- DONE: STALL = 0, ACK = 1, then unconditionally go to IDLE. A request still present in IDLE starts a new access. The requester deasserts or changes the request as the pipeline advances.
- Byte lanes are big-endian. Offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - SB at offset k writes data_write[7:0] into lane k.
  - SH at offset 0 writes data_write[15:0] into [31:16]; at offset 2, into [15:0].
  - SW writes all four lanes.
- Errors: the access is suppressed (no memory change, data_read forced to 0 for reads) and ERR is pulsed with ACK in DONE. An error is any of:
  - MemRead & MemWrite both high.
  - address bits [31:ADDR_WIDTH+2] nonzero.
  - write_size == 3 on a write.
  - Misaligned write: half at odd offset, word at nonzero offset.
- Misaligned reads are not errors.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: data_read = 0, ACK = 0, ERR = 0, state = IDLE, cnt = 0. STALL = req (combinational) while RESET is low.
- While RESET is high, STALL is forced to 0.
- Stall cycles per access = LATENCY. data_read is valid from the DONE cycle until the next access completes.
- Back-to-back requests: one DONE cycle separates accesses. Throughput is one access per LATENCY+1 cycles.
- RESET asserted mid-access (BUSY): return to IDLE immediately. The pending write is discarded; data_read is cleared to 0.
- Request dropped during BUSY: the access still completes; the latched values are used.
- Request fields changing during BUSY are ignored; only values latched in IDLE are used.

## Test plan
- Word write/read, LATENCY = 2:
  - Stimulus: SW 0xDEADBEEF to address 0x40, then LW from 0x40.
  - Required: STALL high exactly 2 cycles per access; ACK in the 3rd cycle; data_read = 0xDEADBEEF.
- Byte lanes:
  - Stimulus: SW 0x11223344 to 0x80, then SB 0xAA at 0x81, then SH 0xBBCC at 0x82, then LW from 0x80.
  - Required: data_read = 0x11AABBCC.
- Errors:
  - Stimulus: SH to 0x85; SW to 0x102; address 0x00001000 with ADDR_WIDTH = 10; MemRead & MemWrite both high.
  - Required: each pulses ERR with ACK, memory is unchanged, and a read returns 0.
- LATENCY = 1 back-to-back:
  - Stimulus: four consecutive LW, request held continuously.
  - Required: STALL pattern 1,0,1,0,1,0,1,0; four ACK pulses.
- Reset mid-access:
  - Stimulus: SW 0x12345678 to 0x10 (prior content 0); assert RESET during BUSY; then LW from 0x10.
  - Required: STALL drops immediately; no ACK; the read returns 0x00000000.
- Fields changing during BUSY:
  - Stimulus: LW 0x20 issued, then data_address changed to 0x24 during BUSY.
  - Required: data_read returns mem[0x20].
